// File: rtl/uart_tx_drain_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
// Holds the transmitter FSM state encoding, the UART data width and the
// default bit period (100 MHz system clock / 115200 baud).
package uart_tx_drain_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_drain_if.sv
// Byte-FIFO read port plus serial output of the UART transmitter.
// master : the transmitter (issues fifo_read, drives tx/busy)
// slave  : the FIFO / line side (supplies empty flag and popped data)
//   fifo_empty      FIFO empty flag
//   fifo_read       one-cycle pop request
//   fifo_data       FIFO data_out
//   fifo_data_valid high the cycle after a successful pop
//   tx              serial line, idle high
//   busy            high from pop request until end of last stop bit
interface uart_tx_drain_if;
  import uart_tx_drain_pkg::*;

  logic                      fifo_empty;
  logic                      fifo_read;
  logic [UART_DATA_BITS-1:0] fifo_data;
  logic                      fifo_data_valid;
  logic                      tx;
  logic                      busy;

  modport master (
    input  fifo_empty, fifo_data, fifo_data_valid,
    output fifo_read, tx, busy
  );

  modport slave (
    output fifo_empty, fifo_data, fifo_data_valid,
    input  fifo_read, tx, busy
  );
endinterface

// File: rtl/uart_tx_drain_baud_tick.sv
// Baud-rate tick generator.
// Counts enabled cycles 0..CLKS_PER_BIT-1 and wraps; tick is high for the one
// enabled cycle in which the count sits at CLKS_PER_BIT-1. A synchronous clear
// restarts the period. Written standalone so a receiver can reuse it.
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   en    : count enable
//   clr   : synchronous clear (wins over en)
//   tick  : end-of-bit-period strobe
module uart_tx_drain_baud_tick
  import uart_tx_drain_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clr && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that drains the comms byte FIFO.
// Pops one byte at a time, then sends it as start bit, 8 data bits LSB first
// and STOP_BITS stop bits. The line idles high while the FIFO is empty.
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset; line returns high immediately
//   bus   : FIFO read port and serial output (master side)
module uart_tx_drain
  import uart_tx_drain_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic             clock,
  input  logic             reset,
  uart_tx_drain_if.master  bus
);

  localparam logic [2:0] DATA_LAST = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_t                 state_q, state_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      fifo_read_q, fifo_read_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_idx_q, bit_idx_d;

  logic baud_en;
  logic baud_tick;

  // The bit-period counter only runs while a frame is on the line; holding it
  // clear elsewhere guarantees the start bit gets a full period from LOAD.
  assign baud_en = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

  uart_tx_drain_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clock (clock),
    .reset (reset),
    .en    (baud_en),
    .clr   (!baud_en),
    .tick  (baud_tick)
  );

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    fifo_read_d = 1'b0;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!bus.fifo_empty) begin
          fifo_read_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = S_POP;
        end
      end
      // FIFO registers the pop during this cycle.
      S_POP: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (bus.fifo_data_valid) begin
          shift_d = bus.fifo_data;
          tx_d    = 1'b0;
          state_d = S_START;
        end else begin
          // Another agent emptied the FIFO first: give up without a frame.
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_tick) begin
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bit_idx_q == DATA_LAST) begin
            tx_d      = 1'b1;
            bit_idx_d = '0;
            state_d   = S_STOP;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      // bit_idx is reused here to count stop-bit periods.
      S_STOP: begin
        if (baud_tick) begin
          if (bit_idx_q == STOP_LAST) begin
            busy_d    = 1'b0;
            bit_idx_d = '0;
            state_d   = S_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      fifo_read_q <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      fifo_read_q <= fifo_read_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
    end
  end

  assign bus.tx        = tx_q;
  assign bus.busy      = busy_q;
  assign bus.fifo_read = fifo_read_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain with CLKS_PER_BIT=4.
// dut1 uses one stop bit, dut2 uses two; each has its own small FIFO model.
module tb_uart_tx_drain;

  localparam int CPB = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  uart_tx_drain_if if1();
  uart_tx_drain_if if2();

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (if1)
  );

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (if2)
  );

  int checks   = 0;
  int failures = 0;

  // FIFO models: write pointer owned by the stimulus, read pointer by the model.
  logic [7:0] mem1 [0:15];
  logic [7:0] mem2 [0:15];
  logic [3:0] wp1 = '0, rp1 = '0;
  logic [3:0] wp2 = '0, rp2 = '0;
  logic [7:0] d1 = '0, d2 = '0;
  logic       v1 = 1'b0, v2 = 1'b0;
  logic       phantom = 1'b0;

  assign if1.fifo_empty      = phantom ? 1'b0 : (wp1 == rp1);
  assign if1.fifo_data       = d1;
  assign if1.fifo_data_valid = v1;
  assign if2.fifo_empty      = (wp2 == rp2);
  assign if2.fifo_data       = d2;
  assign if2.fifo_data_valid = v2;

  always @(posedge clock) begin
    v1 <= 1'b0;
    if (if1.fifo_read && !phantom && (rp1 != wp1)) begin
      d1  <= mem1[rp1];
      v1  <= 1'b1;
      rp1 <= rp1 + 4'd1;
    end
  end

  always @(posedge clock) begin
    v2 <= 1'b0;
    if (if2.fifo_read && (rp2 != wp2)) begin
      d2  <= mem2[rp2];
      v2  <= 1'b1;
      rp2 <= rp2 + 4'd1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic obs(input bit sel, output logic tx, output logic busy, output logic rd);
    if (sel) begin
      tx = if2.tx; busy = if2.busy; rd = if2.fifo_read;
    end else begin
      tx = if1.tx; busy = if1.busy; rd = if1.fifo_read;
    end
  endtask

  task automatic chk_line(input bit sel, input string tag, input logic etx, input logic ebusy, input logic erd);
    logic tx, busy, rd;
    obs(sel, tx, busy, rd);
    check_val({tag, ".tx"},   {31'd0, tx},   {31'd0, etx});
    check_val({tag, ".busy"}, {31'd0, busy}, {31'd0, ebusy});
    check_val({tag, ".read"}, {31'd0, rd},   {31'd0, erd});
  endtask

  task automatic push(input bit sel, input logic [7:0] b);
    if (sel) begin
      mem2[wp2] = b; wp2 = wp2 + 4'd1;
    end else begin
      mem1[wp1] = b; wp1 = wp1 + 4'd1;
    end
  endtask

  // Returns at the negedge where fifo_read is first seen; pop must follow
  // exactly one IDLE cycle.
  task automatic wait_pop(input bit sel, input string tag);
    logic tx, busy, rd;
    int n = 0;
    do begin
      @(negedge clock);
      n++;
      obs(sel, tx, busy, rd);
    end while (!rd && n < 20);
    check_val({tag, ".pop_seen"}, {31'd0, rd}, 32'd1);
    check_val({tag, ".pop_wait"}, n, 32'd1);
  endtask

  // frame[i] is the hand-derived tx level for bit period i (0 = start bit).
  task automatic check_periods(input bit sel, input logic [10:0] frame, input int first, input int last, input string tag);
    for (int i = first * CPB; i < (last + 1) * CPB; i++) begin
      @(negedge clock);
      chk_line(sel, $sformatf("%s.p%0d", tag, i / CPB), frame[i / CPB], 1'b1, 1'b0);
    end
  endtask

  task automatic run_frame(input bit sel, input logic [10:0] frame, input int nstop, input string tag);
    wait_pop(sel, tag);
    chk_line(sel, {tag, ".pop"}, 1'b1, 1'b1, 1'b1);
    @(negedge clock);
    chk_line(sel, {tag, ".load"}, 1'b1, 1'b1, 1'b0);
    check_periods(sel, frame, 0, 8 + nstop, tag);
    @(negedge clock);
    chk_line(sel, {tag, ".idle"}, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset and idle
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk_line(0, "rst1", 1'b1, 1'b0, 1'b0);
    chk_line(1, "rst2", 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      chk_line(0, "idle1", 1'b1, 1'b0, 1'b0);
      chk_line(1, "idle2", 1'b1, 1'b0, 1'b0);
    end

    // Single byte 0xA5
    push(0, 8'hA5);
    run_frame(0, 11'h74A, 1, "a5");
    repeat (5) begin
      @(negedge clock);
      chk_line(0, "a5.after", 1'b1, 1'b0, 1'b0);
    end

    // Back-to-back 0x00 then 0xFF: exactly IDLE, POP, LOAD high between frames
    push(0, 8'h00);
    push(0, 8'hFF);
    run_frame(0, 11'h600, 1, "b2b0");
    run_frame(0, 11'h7FE, 1, "b2b1");
    repeat (5) begin
      @(negedge clock);
      chk_line(0, "b2b.after", 1'b1, 1'b0, 1'b0);
    end

    // Phantom empty: pop issued but no data returned
    phantom = 1'b1;
    wait_pop(0, "ph");
    chk_line(0, "ph.pop", 1'b1, 1'b1, 1'b1);
    @(negedge clock);
    chk_line(0, "ph.load", 1'b1, 1'b1, 1'b0);
    @(negedge clock);
    chk_line(0, "ph.idle", 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    chk_line(0, "ph.repop", 1'b1, 1'b1, 1'b1);
    phantom = 1'b0;
    @(negedge clock);
    chk_line(0, "ph.load2", 1'b1, 1'b1, 1'b0);
    repeat (5) begin
      @(negedge clock);
      chk_line(0, "ph.after", 1'b1, 1'b0, 1'b0);
    end

    // Mid-frame reset during data bit 3 of 0x3C
    push(0, 8'h3C);
    wait_pop(0, "mr");
    chk_line(0, "mr.pop", 1'b1, 1'b1, 1'b1);
    @(negedge clock);
    chk_line(0, "mr.load", 1'b1, 1'b1, 1'b0);
    check_periods(0, 11'h678, 0, 3, "mr");
    @(negedge clock);
    chk_line(0, "mr.bit3", 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    chk_line(0, "mr.async", 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      chk_line(0, "mr.quiet", 1'b1, 1'b0, 1'b0);
    end
    check_val("mr.fifo_drained", {28'd0, rp1}, {28'd0, wp1});

    // Two stop bits, byte 0x81, 44-cycle frame
    push(1, 8'h81);
    run_frame(1, 11'h702, 2, "s2");
    repeat (5) begin
      @(negedge clock);
      chk_line(1, "s2.after", 1'b1, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
- Byte-serial UART transmitter that sits directly downstream of the comms byte FIFO.
- Pops one byte at a time through the FIFO's read/data_out/data_out_valid interface.
- Serialises each byte onto the tx line as an 8N1 frame (configurable stop bits), LSB first.
- Holds the line idle-high whenever the FIFO is empty.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit period (100 MHz / 115200); legal range >= 2
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clock  in  1  single system clock, rising-edge
reset  in  1  asynchronous, active-low reset; all state clears immediately when low
fifo_empty  in  1  FIFO empty flag
fifo_read  out  1  one-cycle pop request to FIFO
fifo_data  in  8  FIFO data_out
fifo_data_valid  in  1  FIFO data_out_valid; high the cycle after a successful pop
tx  out  1  serial line, idle high
busy  out  1  high from pop request until end of last stop bit

Behaviour:
- Reset (reset low, async) forces the following:
  - state=IDLE, tx=1, busy=0, fifo_read=0
  - bit counter=0, baud counter=0, shift register=0
- Deassertion of reset is sampled on clock; the first active edge evaluates IDLE.
- fifo_read is registered.
- FSM states: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - If fifo_empty==0: fifo_read<=1 for exactly one cycle, busy<=1, go to POP.
  - Otherwise stay in IDLE.
- POP:
  - fifo_read<=0.
  - Go to LOAD. This cycle is the FIFO's registered read.
- LOAD:
  - If fifo_data_valid==1: shift<=fifo_data, baud counter<=0, tx<=0, go to START.
  - If fifo_data_valid==0 (FIFO drained by another agent): go to IDLE, busy<=0, no frame emitted.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles, counted from the cycle tx first reads 0.
  - On the last cycle: tx<=shift[0], bit index<=0, go to DATA.
- DATA:
  - Each bit is held CLKS_PER_BIT cycles.
  - At the end of each bit period, shift right by 1 and increment the bit index.
  - After bit 7's period: tx<=1, go to STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the last cycle go to IDLE, busy<=0.
- Frame length: (10 + STOP_BITS - 1) * CLKS_PER_BIT cycles of start+data+stop.
- Back-to-back traffic:
  - Minimum inter-frame overhead is 3 cycles (IDLE, POP, LOAD) with tx high.
  - No other gaps.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0.
  - The tick fires at CLKS_PER_BIT-1.
- Bit index is 3 bits; comparison with 7 terminates DATA.
- Only one outstanding pop at a time:
  - fifo_read is never asserted outside IDLE.
  - fifo_read is never asserted on two consecutive cycles.
- fifo_data_valid asserted in any state other than LOAD is ignored.
- fifo_empty toggling mid-frame has no effect on the current frame.
- Reset low mid-frame:
  - tx returns high immediately (async).
  - The partial frame is abandoned.
  - The popped byte is lost (not re-queued).

Decomposition:
- comms_pkg holds:
  - state encoding for the FSM (IDLE, POP, LOAD, START, DATA, STOP)
  - UART_DATA_BITS=8
  - default CLKS_PER_BIT constant
- One sub-module is natural: baud_tick.
  - Parameterised counter with enable and synchronous clear.
  - Emits a one-cycle tick every CLKS_PER_BIT enabled cycles.
  - Shares the async active-low reset.
  - Reusable by a future uart_rx feeding the FIFO.

Test Plan:
- Reset/idle: reset low, then high, fifo_empty=1 for 100 cycles -> tx=1, busy=0, fifo_read=0 throughout.
- Single byte (CLKS_PER_BIT=4, STOP_BITS=1):
  - Stimulus: FIFO model holds 0xA5, fifo_empty=0.
  - fifo_read is a single-cycle pulse.
  - tx sequence per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 1 (40 cycles).
  - busy falls on the last stop cycle.
- Back-to-back: FIFO holds 0x00, 0xFF -> two frames separated by exactly 3 high cycles; second frame's data bits all 1.
- Phantom empty: fifo_empty=0 but fifo_data_valid never asserted -> FSM returns to IDLE after LOAD, tx stays 1, fifo_read pulses again next IDLE cycle.
- Mid-frame reset: assert reset during DATA bit 3 of 0x3C -> tx=1 same cycle (async); after release with FIFO empty, no further activity.
- Two stop bits (STOP_BITS=2, CLKS_PER_BIT=4), byte 0x81 -> frame of 44 cycles, last 8 cycles tx=1, and fifo_read does not assert before they elapse.
